// File: rtl/jpeg_pipe_sequencer_pkg.sv
// Shared types and default stage offsets for the JPEG frame sequencer.
package jpeg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } seq_state_e;

  // Cycles from the first input read to the first row of each later stage.
  localparam int OFS_TP2 = 9;
  localparam int OFS_ZZ  = 18;
  localparam int OFS_WR  = 27;

endpackage

// File: rtl/jpeg_pipe_sequencer_if.sv
// Handshake and SRAM/stage-control bundle between a frame requester and the sequencer.
// The stall signal exists only when JPEG_SEQ_STALL_EN is defined.
interface jpeg_seq_if #(
  parameter int ADDR_W = 15,
  parameter int BLK_W  = 12
) ();

  logic              start;
  logic [BLK_W-1:0]  num_blocks;
`ifdef JPEG_SEQ_STALL_EN
  logic              stall;
`endif
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        row1;
  logic [2:0]        row2;
  logic [2:0]        rowq;
  logic              sel_tp1;
  logic              sel_tp2;
  logic              sel_zz;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
`ifdef JPEG_SEQ_STALL_EN
    output stall,
`endif
    output start, num_blocks,
    input  busy, done, rd_en, rd_addr, row1, row2, rowq,
    input  sel_tp1, sel_tp2, sel_zz, wr_en, wr_addr
  );

  modport slave (
`ifdef JPEG_SEQ_STALL_EN
    input  stall,
`endif
    input  start, num_blocks,
    output busy, done, rd_en, rd_addr, row1, row2, rowq,
    output sel_tp1, sel_tp2, sel_zz, wr_en, wr_addr
  );

endinterface

// File: rtl/jpeg_pipe_sequencer_stage_window.sv
// Decides whether a stage's window [base, base+len) covers t and returns its local index.
module stage_window #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 15
) (
  input  logic [CNT_W-1:0] t,
  input  logic [CNT_W-1:0] base,
  input  logic [CNT_W-1:0] len,
  output logic             active,
  output logic [IDX_W-1:0] idx
);

  logic [CNT_W-1:0] diff;

  // Subtracting first keeps base+len from ever overflowing the counter width.
  always_comb begin
    diff   = t - base;
    active = (t >= base) && (diff < len);
    idx    = diff[IDX_W-1:0];
  end

endmodule

// File: rtl/jpeg_pipe_sequencer.sv
// Frame-level controller for the JPEG pipeline: start/busy/done handshake, read/write
// addresses, per-stage rows and ping-pong selects. Optional freeze via JPEG_SEQ_STALL_EN.
module jpeg_pipe_sequencer #(
  parameter int ADDR_W  = 15,
  parameter int BLK_W   = 12,
  parameter int OFS_TP2 = jpeg_seq_pkg::OFS_TP2,
  parameter int OFS_ZZ  = jpeg_seq_pkg::OFS_ZZ,
  parameter int OFS_WR  = jpeg_seq_pkg::OFS_WR
) (
  input logic       clk,
  input logic       reset,
  jpeg_seq_if.slave bus
);

  import jpeg_seq_pkg::*;

  localparam int CNT_W = ADDR_W + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t BASE_RD  = '0;
  localparam cnt_t BASE_TP2 = cnt_t'(OFS_TP2);
  localparam cnt_t BASE_ZZ  = cnt_t'(OFS_ZZ);
  localparam cnt_t BASE_WR  = cnt_t'(OFS_WR);

  seq_state_e state_q, state_d;
  cnt_t       t_q, t_d;
  cnt_t       len_q, len_d;
  cnt_t       len_eff;
  cnt_t       last_t;
  logic       stall_run;

  logic              rd_act, tp2_act, zz_act, wr_act;
  logic [ADDR_W-1:0] rd_idx, wr_idx;
  logic [3:0]        tp2_idx, zz_idx;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]        row1_q, row1_d;
  logic [2:0]        row2_q, row2_d;
  logic [2:0]        rowq_q, rowq_d;
  logic              sel_tp1_q, sel_tp1_d;
  logic              sel_tp2_q, sel_tp2_d;
  logic              sel_zz_q, sel_zz_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

`ifdef JPEG_SEQ_STALL_EN
  assign stall_run = bus.stall && (state_q == ST_RUN);
`else
  assign stall_run = 1'b0;
`endif

  assign last_t = BASE_WR + len_q - cnt_t'(1);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.num_blocks != '0) begin
            state_d = ST_RUN;
            t_d     = '0;
            len_d   = cnt_t'({bus.num_blocks, 3'b000});
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        if (!stall_run) begin
          if (t_q == last_t) state_d = ST_FIN;
          else               t_d     = t_q + cnt_t'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-cycle state so they line up with the t they describe;
  // a zero window length outside RUN closes every stage at once.
  assign len_eff = (state_d == ST_RUN) ? len_d : '0;

  stage_window #(.CNT_W(CNT_W), .IDX_W(ADDR_W)) u_win_rd (
    .t(t_d), .base(BASE_RD), .len(len_eff), .active(rd_act), .idx(rd_idx));
  stage_window #(.CNT_W(CNT_W), .IDX_W(4)) u_win_tp2 (
    .t(t_d), .base(BASE_TP2), .len(len_eff), .active(tp2_act), .idx(tp2_idx));
  stage_window #(.CNT_W(CNT_W), .IDX_W(4)) u_win_zz (
    .t(t_d), .base(BASE_ZZ), .len(len_eff), .active(zz_act), .idx(zz_idx));
  stage_window #(.CNT_W(CNT_W), .IDX_W(ADDR_W)) u_win_wr (
    .t(t_d), .base(BASE_WR), .len(len_eff), .active(wr_act), .idx(wr_idx));

  always_comb begin
    busy_d    = (state_d == ST_RUN);
    done_d    = (state_d == ST_FIN);
    rd_en_d   = rd_act && !stall_run;
    rd_addr_d = rd_act ? rd_idx : '0;
    row1_d    = rd_act ? rd_idx[2:0] : 3'd0;
    sel_tp1_d = ~(rd_act & rd_idx[3]);
    row2_d    = tp2_act ? tp2_idx[2:0] : 3'd0;
    sel_tp2_d = ~(tp2_act & tp2_idx[3]);
    rowq_d    = zz_act ? zz_idx[2:0] : 3'd0;
    sel_zz_d  = ~(zz_act & zz_idx[3]);
    wr_en_d   = wr_act && !stall_run;
    wr_addr_d = wr_act ? wr_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      row1_q    <= 3'd0;
      row2_q    <= 3'd0;
      rowq_q    <= 3'd0;
      sel_tp1_q <= 1'b1;
      sel_tp2_q <= 1'b1;
      sel_zz_q  <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      row1_q    <= row1_d;
      row2_q    <= row2_d;
      rowq_q    <= rowq_d;
      sel_tp1_q <= sel_tp1_d;
      sel_tp2_q <= sel_tp2_d;
      sel_zz_q  <= sel_zz_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.row1    = row1_q;
  assign bus.row2    = row2_q;
  assign bus.rowq    = rowq_q;
  assign bus.sel_tp1 = sel_tp1_q;
  assign bus.sel_tp2 = sel_tp2_q;
  assign bus.sel_zz  = sel_zz_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;

endmodule

// File: tb/tb_jpeg_pipe_sequencer.sv
// Directed bench for jpeg_pipe_sequencer: frame timing, ping-pong selects, zero-block frames,
// ignored restarts, mid-frame reset and (with JPEG_SEQ_STALL_EN) stall behaviour.
module tb_jpeg_pipe_sequencer;

  localparam int T_TP2 = 9;
  localparam int T_ZZ  = 18;
  localparam int T_WR  = 27;
  localparam int IDLE_T = 100000;  // any t past the end of a frame means "idle expected"

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  jpeg_seq_if bus ();

  jpeg_pipe_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for a frame of R rows at effective time te (window formulas from the block description).
  task automatic chk_cycle(input string name, input int te, input int r, input bit en_ok);
    bit run   = (te <= T_WR + r - 1);
    bit fin   = (te == T_WR + r);
    bit a_rd  = run && (te < r);
    bit a_tp2 = run && (te >= T_TP2) && (te < T_TP2 + r);
    bit a_zz  = run && (te >= T_ZZ) && (te < T_ZZ + r);
    bit a_wr  = run && (te >= T_WR) && (te < T_WR + r);
    int i2    = te - T_TP2;
    int iz    = te - T_ZZ;
    int iw    = te - T_WR;
    chk($sformatf("%s t=%0d busy", name, te),    32'(bus.busy),    32'(run));
    chk($sformatf("%s t=%0d done", name, te),    32'(bus.done),    32'(fin));
    chk($sformatf("%s t=%0d rd_en", name, te),   32'(bus.rd_en),   32'(a_rd && en_ok));
    chk($sformatf("%s t=%0d rd_addr", name, te), 32'(bus.rd_addr), a_rd ? 32'(te) : 32'd0);
    chk($sformatf("%s t=%0d row1", name, te),    32'(bus.row1),    a_rd ? 32'(te % 8) : 32'd0);
    chk($sformatf("%s t=%0d sel_tp1", name, te), 32'(bus.sel_tp1), a_rd ? 32'((te / 8) % 2 == 0) : 32'd1);
    chk($sformatf("%s t=%0d row2", name, te),    32'(bus.row2),    a_tp2 ? 32'(i2 % 8) : 32'd0);
    chk($sformatf("%s t=%0d sel_tp2", name, te), 32'(bus.sel_tp2), a_tp2 ? 32'((i2 / 8) % 2 == 0) : 32'd1);
    chk($sformatf("%s t=%0d rowq", name, te),    32'(bus.rowq),    a_zz ? 32'(iz % 8) : 32'd0);
    chk($sformatf("%s t=%0d sel_zz", name, te),  32'(bus.sel_zz),  a_zz ? 32'((iz / 8) % 2 == 0) : 32'd1);
    chk($sformatf("%s t=%0d wr_en", name, te),   32'(bus.wr_en),   32'(a_wr && en_ok));
    chk($sformatf("%s t=%0d wr_addr", name, te), 32'(bus.wr_addr), a_wr ? 32'(iw) : 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.num_blocks = '0;
`ifdef JPEG_SEQ_STALL_EN
    bus.stall      = 1'b0;
`endif
    tick();
    tick();
    chk_cycle("reset", IDLE_T, 8, 1'b1);
    reset = 1'b1;
    tick();
    chk_cycle("idle", IDLE_T, 8, 1'b1);

    // 1: single block
    bus.num_blocks = 12'd1;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    for (int c = 0; c <= 38; c++) begin
      chk_cycle("nb1", c, 8, 1'b1);
      tick();
    end

    // 2: two blocks, selects toggle after the first 8 rows of each stage
    bus.num_blocks = 12'd2;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    for (int c = 0; c <= 46; c++) begin
      chk_cycle("nb2", c, 16, 1'b1);
      tick();
    end

    // 3: zero blocks completes immediately without strobes
    bus.num_blocks = 12'd0;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    chk("nb0 done", 32'(bus.done), 32'd1);
    chk("nb0 busy", 32'(bus.busy), 32'd0);
    chk("nb0 rd_en", 32'(bus.rd_en), 32'd0);
    chk("nb0 wr_en", 32'(bus.wr_en), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cycle("nb0 after", IDLE_T, 8, 1'b1);
    end

    // 4: restart during a frame is ignored
    bus.num_blocks = 12'd1;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    for (int c = 0; c <= 38; c++) begin
      chk_cycle("restart", c, 8, 1'b1);
      if (c == 5) begin
        bus.start      = 1'b1;
        bus.num_blocks = 12'd3;
      end
      tick();
      bus.start = 1'b0;
    end

    // 5: reset mid-frame, then a fresh frame
    bus.num_blocks = 12'd2;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      chk_cycle("prerst", c, 16, 1'b1);
      if (c == 20) reset = 1'b0;
      tick();
    end
    chk_cycle("midrst", IDLE_T, 16, 1'b1);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_cycle("postrst idle", IDLE_T, 16, 1'b1);
    end
    bus.num_blocks = 12'd1;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    for (int c = 0; c <= 38; c++) begin
      chk_cycle("fresh", c, 8, 1'b1);
      tick();
    end

`ifdef JPEG_SEQ_STALL_EN
    // 6: four stall cycles sampled while t=3 freeze the frame and stretch done by 4
    bus.num_blocks = 12'd1;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    for (int c = 0; c <= 42; c++) begin
      int te;
      bit en_ok;
      te    = (c <= 3) ? c : ((c <= 7) ? 3 : c - 4);
      en_ok = !((c >= 4) && (c <= 7));
      chk_cycle("stall", te, 8, en_ok);
      bus.stall = (c >= 3) && (c <= 6);
      tick();
    end
    bus.stall = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
